// File: rtl/id_hazard_ctrl_if.sv
// Decode-stage interlock bus: the decode instruction's register fields going in,
// and the pipeline hold/bubble/flush controls plus status coming back.
interface id_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid_in;
    logic [4:0]       id_rs1_in;
    logic [4:0]       id_rs2_in;
    logic             id_rs1_use_in;
    logic             id_rs2_use_in;
    logic [4:0]       id_rd_in;
    logic             id_wen_in;
    logic             id_load_in;
    logic             jump_taken_in;
    logic             ex_busy_in;

    logic             stall_out;
    logic             bubble_out;
    logic             hold_ex_out;
    logic             flush_ifid_out;
    logic [1:0]       state_out;
    logic [CNT_W-1:0] stall_cnt_out;

    // The pipeline (decode/EX side) drives the instruction fields and sees the controls.
    modport master (
        output id_valid_in, id_rs1_in, id_rs2_in, id_rs1_use_in, id_rs2_use_in,
               id_rd_in, id_wen_in, id_load_in, jump_taken_in, ex_busy_in,
        input  stall_out, bubble_out, hold_ex_out, flush_ifid_out, state_out,
               stall_cnt_out
    );

    modport slave (
        input  id_valid_in, id_rs1_in, id_rs2_in, id_rs1_use_in, id_rs2_use_in,
               id_rd_in, id_wen_in, id_load_in, jump_taken_in, ex_busy_in,
        output stall_out, bubble_out, hold_ex_out, flush_ifid_out, state_out,
               stall_cnt_out
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Decode-stage interlock: scoreboard of in-flight writes (EX/MEM/WB), RAW and
// load-use detection, multi-cycle EX hold, and wrong-path flush on decode jumps.
module id_hazard_ctrl #(
    parameter int DEPTH  = 3,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    id_hazard_ctrl_if.slave bus
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       load;
    } sb_entry_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HAZ  = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    sb_entry_t        sb [DEPTH];
    sb_entry_t        new_entry;
    logic [DEPTH-1:0] hit;
    logic             hazard;
    logic             issue;
    logic             stall;
    state_t           state;
    logic [CNT_W-1:0] stall_cnt;

    // Per-entry source match; rd==0 entries are never valid, and rs==0 is excluded too.
    always_comb begin
        // NOTE: give every always_comb target a default first so no path can infer a latch.
        hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit[k] = (bus.id_rs1_use_in && sb[k].valid && bus.id_rs1_in != 5'd0 &&
                      sb[k].rd == bus.id_rs1_in) ||
                     (bus.id_rs2_use_in && sb[k].valid && bus.id_rs2_in != 5'd0 &&
                      sb[k].rd == bus.id_rs2_in);
        end
    end

    // With full forwarding only a load still in EX cannot deliver its result in time.
    assign hazard = FWD_EN ? (hit[0] && sb[0].load) : (|hit);

    assign issue = bus.id_valid_in && !hazard && !bus.ex_busy_in;
    assign stall = bus.id_valid_in && (hazard || bus.ex_busy_in);

    always_comb begin
        new_entry       = '0;
        new_entry.valid = bus.id_wen_in && (bus.id_rd_in != 5'd0);
        new_entry.rd    = bus.id_rd_in;
        new_entry.load  = bus.id_load_in;
    end

    // Controls are combinational and squashed while reset is held.
    assign bus.stall_out      = !rst && stall;
    assign bus.hold_ex_out    = !rst && bus.ex_busy_in;
    assign bus.bubble_out     = !rst && bus.id_valid_in && hazard && !bus.ex_busy_in;
    assign bus.flush_ifid_out = !rst && bus.jump_taken_in && issue;
    assign bus.state_out      = state;
    assign bus.stall_cnt_out  = stall_cnt;

    // Scoreboard mirrors EX..WB; a busy EX keeps its entry and sends a bubble to MEM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this small flop array is reset (unlike a RAM) because a stale valid bit
            // would stall the first instructions after reset.
            for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
        end else if (!bus.ex_busy_in) begin
            // NOTE: non-blocking assignments make every entry shift from its pre-edge value.
            sb[0] <= issue ? new_entry : '0;
            for (int k = 1; k < DEPTH; k++) sb[k] <= sb[k-1];
        end else begin
            for (int k = 1; k < DEPTH; k++) sb[k] <= (k == 1) ? '0 : sb[k-1];
        end
    end

    // Registered stall cause; busy outranks a pending hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else if (bus.ex_busy_in) begin
            state <= ST_BUSY;
        end else if (bus.id_valid_in && hazard) begin
            state <= ST_HAZ;
        end else begin
            state <= ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // A bubble and an EX hold on the same ID/EX register would contradict each other.
    a_bubble_hold_excl: assert property (@(posedge clk) disable iff (rst)
        !(bus.bubble_out && bus.hold_ex_out));

    a_flush_needs_issue: assert property (@(posedge clk) disable iff (rst)
        !(bus.flush_ifid_out && bus.stall_out));

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: three instances (forwarding, no forwarding,
// 4-bit counter) share one stimulus stream; expected values are hand-derived.
module tb_id_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       valid, u1, u2, wen, ld, jmp, busy;
    logic [4:0] rs1, rs2, rd;

    int checks = 0;
    int errors = 0;

    id_hazard_ctrl_if #(.CNT_W(16)) ifa ();
    id_hazard_ctrl_if #(.CNT_W(16)) ifb ();
    id_hazard_ctrl_if #(.CNT_W(4))  ifc ();

    assign ifa.id_valid_in = valid;  assign ifb.id_valid_in = valid;  assign ifc.id_valid_in = valid;
    assign ifa.id_rs1_in   = rs1;    assign ifb.id_rs1_in   = rs1;    assign ifc.id_rs1_in   = rs1;
    assign ifa.id_rs2_in   = rs2;    assign ifb.id_rs2_in   = rs2;    assign ifc.id_rs2_in   = rs2;
    assign ifa.id_rs1_use_in = u1;   assign ifb.id_rs1_use_in = u1;   assign ifc.id_rs1_use_in = u1;
    assign ifa.id_rs2_use_in = u2;   assign ifb.id_rs2_use_in = u2;   assign ifc.id_rs2_use_in = u2;
    assign ifa.id_rd_in    = rd;     assign ifb.id_rd_in    = rd;     assign ifc.id_rd_in    = rd;
    assign ifa.id_wen_in   = wen;    assign ifb.id_wen_in   = wen;    assign ifc.id_wen_in   = wen;
    assign ifa.id_load_in  = ld;     assign ifb.id_load_in  = ld;     assign ifc.id_load_in  = ld;
    assign ifa.jump_taken_in = jmp;  assign ifb.jump_taken_in = jmp;  assign ifc.jump_taken_in = jmp;
    assign ifa.ex_busy_in  = busy;   assign ifb.ex_busy_in  = busy;   assign ifc.ex_busy_in  = busy;

    id_hazard_ctrl #(.DEPTH(3), .FWD_EN(1'b1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    id_hazard_ctrl #(.DEPTH(3), .FWD_EN(1'b0), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    id_hazard_ctrl #(.DEPTH(3), .FWD_EN(1'b1), .CNT_W(4))  dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic us1,
                         input logic [4:0] r2, input logic us2, input logic [4:0] d,
                         input logic w, input logic l, input logic j, input logic b);
        valid = v; rs1 = r1; u1 = us1; rs2 = r2; u2 = us2;
        rd = d; wen = w; ld = l; jmp = j; busy = b;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // Load-use with forwarding: one bubble, then issue.
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);  // lw x5
        @(negedge clk);
        check("lu_lw_stall", ifa.stall_out, 1'b0);
        check("lu_reset_state", ifa.state_out, 2'd0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); // add x6,x5,x1
        @(negedge clk);
        check("lu_stall", ifa.stall_out, 1'b1);
        check("lu_bubble", ifa.bubble_out, 1'b1);
        check("lu_hold_ex", ifa.hold_ex_out, 1'b0);
        tick();
        @(negedge clk);
        check("lu_issue_stall", ifa.stall_out, 1'b0);
        check("lu_state_haz", ifa.state_out, 2'd1);
        check("lu_cnt", ifa.stall_cnt_out, 16'd1);
        tick();
        idle();
        @(negedge clk);
        check("lu_state_run", ifa.state_out, 2'd0);

        // Plain RAW: free with forwarding, three stalls without.
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);  // add x5
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); // sub x7,x5,x2
        @(negedge clk);
        check("raw_fwd_stall", ifa.stall_out, 1'b0);
        check("raw_nofwd_stall1", ifb.stall_out, 1'b1);
        check("raw_nofwd_bubble", ifb.bubble_out, 1'b1);
        tick();
        @(negedge clk);
        check("raw_nofwd_stall2", ifb.stall_out, 1'b1);
        tick();
        @(negedge clk);
        check("raw_nofwd_stall3", ifb.stall_out, 1'b1);
        tick();
        @(negedge clk);
        check("raw_nofwd_clear", ifb.stall_out, 1'b0);
        check("raw_nofwd_cnt", ifb.stall_cnt_out, 16'd3);
        check("raw_fwd_cnt", ifa.stall_cnt_out, 16'd0);
        check("raw_nofwd_state", ifb.state_out, 2'd1);
        tick();

        // x0 is never tracked.
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);  // lw x0
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("x0_fwd_stall", ifa.stall_out, 1'b0);
        check("x0_nofwd_stall", ifb.stall_out, 1'b0);
        tick();
        @(negedge clk);
        check("x0_nofwd_stall2", ifb.stall_out, 1'b0);
        tick();

        // Multi-cycle EX busy holding a load, then the dependent reader.
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);  // lw x7
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            check("busy_hold_ex", ifa.hold_ex_out, 1'b1);
            check("busy_bubble", ifa.bubble_out, 1'b0);
            check("busy_stall", ifa.stall_out, 1'b1);
            if (i > 0) check("busy_state", ifa.state_out, 2'd2);
            tick();
        end
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("busy_drop_bubble", ifa.bubble_out, 1'b1);
        check("busy_drop_hold", ifa.hold_ex_out, 1'b0);
        check("busy_drop_state", ifa.state_out, 2'd2);
        tick();
        @(negedge clk);
        check("busy_issue", ifa.stall_out, 1'b0);
        check("busy_haz_state", ifa.state_out, 2'd1);
        check("busy_cnt", ifa.stall_cnt_out, 16'd5);
        tick();

        // Jump flush, plain and delayed by a load-use hazard.
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("jmp_flush", ifa.flush_ifid_out, 1'b1);
        tick();
        idle();
        @(negedge clk);
        check("jmp_flush_once", ifa.flush_ifid_out, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);  // lw x5
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); // branch on x5
        @(negedge clk);
        check("jmp_haz_flush", ifa.flush_ifid_out, 1'b0);
        check("jmp_haz_stall", ifa.stall_out, 1'b1);
        tick();
        @(negedge clk);
        check("jmp_late_flush", ifa.flush_ifid_out, 1'b1);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("jmp_busy_flush", ifa.flush_ifid_out, 1'b0);
        tick();

        // Counter saturation and asynchronous reset mid-stall.
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);  // lw x9
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
            tick();
        end
        @(negedge clk);
        check("sat_cnt4", ifc.stall_cnt_out, 32'd15);
        check("sat_cnt16", ifa.stall_cnt_out, 32'd20);
        check("pre_rst_stall", ifa.stall_out, 1'b1);
        check("pre_rst_state", ifa.state_out, 2'd2);
        #1 rst = 1'b1;
        #1;
        check("rst_stall", ifa.stall_out, 1'b0);
        check("rst_hold_ex", ifa.hold_ex_out, 1'b0);
        check("rst_bubble", ifa.bubble_out, 1'b0);
        check("rst_flush", ifa.flush_ifid_out, 1'b0);
        check("rst_state", ifa.state_out, 2'd0);
        check("rst_cnt", ifa.stall_cnt_out, 16'd0);
        check("rst_cnt4", ifc.stall_cnt_out, 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("post_rst_stall", ifa.stall_out, 1'b0);
        check("post_rst_nofwd", ifb.stall_out, 1'b0);
        check("post_rst_state", ifa.state_out, 2'd0);
        tick();
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
